// File: rtl/cachepool_pkg.sv
// Shared cachepool constants and the address-interleave helpers used by the L2 channel router.
package cachepool_pkg;

   localparam int unsigned NumL2Channel = 4;
   localparam int unsigned L2BankWidth  = 512;
   localparam int unsigned L2Interleave = 128;
   localparam int unsigned MaxAddrWidth = 64;

   typedef logic [MaxAddrWidth-1:0] wide_addr_t;

   // Number of byte-offset bits covered by one channel granule.
   function automatic int unsigned chan_offset_bits(input int unsigned data_width,
                                                    input int unsigned interleave);
      return $clog2(data_width / 8 * interleave);
   endfunction

   // Number of address bits that select a channel.
   function automatic int unsigned chan_sel_bits(input int unsigned num_ch);
      return $clog2(num_ch);
   endfunction

   localparam int unsigned CB = chan_offset_bits(L2BankWidth, L2Interleave);
   localparam int unsigned SB = chan_sel_bits(NumL2Channel);

   // Channel ID is the sb-bit field sitting directly above the granule offset.
   function automatic wide_addr_t chan_id(input wide_addr_t addr,
                                          input int unsigned cb,
                                          input int unsigned sb);
      wide_addr_t mask;
      mask = (wide_addr_t'(1) << sb) - wide_addr_t'(1);
      return (addr >> cb) & mask;
   endfunction

   // Channel-local address: the channel-select field is zeroed, all other bits kept.
   function automatic wide_addr_t chan_addr(input wide_addr_t addr,
                                            input int unsigned cb,
                                            input int unsigned sb);
      wide_addr_t low_mask;
      wide_addr_t hi_mask;
      low_mask = (wide_addr_t'(1) << cb) - wide_addr_t'(1);
      hi_mask  = ~((wide_addr_t'(1) << (cb + sb)) - wide_addr_t'(1));
      return (addr & hi_mask) | (addr & low_mask);
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Simple synchronous FIFO with wrap-around pointers and an exact fill count.
module fifo_v3 #(
   parameter int unsigned DataWidth = 8,
   parameter int unsigned Depth     = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [DataWidth-1:0]         data_i,
   input  logic                         pop_i,
   output logic [DataWidth-1:0]         data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   usage_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [DataWidth-1:0] mem_q [Depth];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic                 push_ok, pop_ok;

   // Status flags derived from the fill count.
   always_comb begin
      full_o  = (count_q == CntW'(Depth));
      empty_o = (count_q == '0);
      usage_o = count_q;
      data_o  = mem_q[rd_ptr_q];
   end

   // Pointer and count update; a push is refused when full even if a pop happens.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_ok  = push_i && !full_o;
      pop_ok   = pop_i && !empty_o;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset since the count gates visibility.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/l2_chan_router.sv
// Routes upstream requests to interleaved L2 channels and returns responses in request order.
module l2_chan_router
   import cachepool_pkg::*;
#(
   parameter int unsigned NumCh      = NumL2Channel,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = L2BankWidth,
   parameter int unsigned Interleave = 128,
   parameter int unsigned OrderDepth = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   // upstream request
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [AddrWidth-1:0]          req_addr_i,
   input  logic                          req_write_i,
   input  logic [DataWidth-1:0]          req_wdata_i,
   input  logic [DataWidth/8-1:0]        req_strb_i,
   // channel request
   output logic [NumCh-1:0]              ch_req_valid_o,
   input  logic [NumCh-1:0]              ch_req_ready_i,
   output logic [AddrWidth-1:0]          ch_req_addr_o,
   output logic                          ch_req_write_o,
   output logic [DataWidth-1:0]          ch_req_wdata_o,
   output logic [DataWidth/8-1:0]        ch_req_strb_o,
   // channel response
   input  logic [NumCh-1:0]              ch_rsp_valid_i,
   output logic [NumCh-1:0]              ch_rsp_ready_o,
   input  logic [NumCh*DataWidth-1:0]    ch_rsp_rdata_i,
   // upstream response
   output logic                          rsp_valid_o,
   input  logic                          rsp_ready_i,
   output logic [DataWidth-1:0]          rsp_rdata_o,
   output logic                          rsp_write_o,
   // status
   output logic [$clog2(OrderDepth)+1-1:0] outstanding_o
);

   localparam int unsigned Cb    = chan_offset_bits(DataWidth, Interleave);
   localparam int unsigned Sb    = chan_sel_bits(NumCh);
   localparam int unsigned IdW   = (Sb > 0) ? Sb : 1;
   localparam int unsigned StrbW = DataWidth / 8;
   localparam int unsigned CntW  = $clog2(OrderDepth) + 1;

   typedef struct packed {
      logic [IdW-1:0] id;
      logic           write;
   } order_entry_t;

   logic                 slot_valid_q, slot_valid_d;
   logic [AddrWidth-1:0] slot_addr_q,  slot_addr_d;
   logic                 slot_write_q, slot_write_d;
   logic [DataWidth-1:0] slot_wdata_q, slot_wdata_d;
   logic [StrbW-1:0]     slot_strb_q,  slot_strb_d;
   logic [IdW-1:0]       slot_id_q,    slot_id_d;

   logic [IdW-1:0]       req_id;
   logic [AddrWidth-1:0] req_ch_addr;
   logic                 slot_drain;
   logic                 accept;
   logic                 pop;
   logic                 order_full;
   logic                 order_empty;
   logic [CntW-1:0]      order_usage;
   order_entry_t         push_entry;
   order_entry_t         head;

   // Address decode of the incoming request.
   always_comb begin
      req_id      = IdW'(chan_id(wide_addr_t'(req_addr_i), Cb, Sb));
      req_ch_addr = AddrWidth'(chan_addr(wide_addr_t'(req_addr_i), Cb, Sb));
      push_entry  = '{id: req_id, write: req_write_i};
   end

   // Request handshake: the slot may refill in the cycle it drains.
   always_comb begin
      slot_drain  = slot_valid_q && ch_req_ready_i[slot_id_q];
      req_ready_o = !order_full && (!slot_valid_q || slot_drain);
      accept      = req_valid_i && req_ready_o;
   end

   // Output slot next-state.
   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_addr_d  = slot_addr_q;
      slot_write_d = slot_write_q;
      slot_wdata_d = slot_wdata_q;
      slot_strb_d  = slot_strb_q;
      slot_id_d    = slot_id_q;
      if (accept) begin
         slot_valid_d = 1'b1;
         slot_addr_d  = req_ch_addr;
         slot_write_d = req_write_i;
         slot_wdata_d = req_wdata_i;
         slot_strb_d  = req_strb_i;
         slot_id_d    = req_id;
      end else if (slot_drain) begin
         slot_valid_d = 1'b0;
      end
   end

   // Output slot register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_valid_q <= 1'b0;
         slot_addr_q  <= '0;
         slot_write_q <= 1'b0;
         slot_wdata_q <= '0;
         slot_strb_q  <= '0;
         slot_id_q    <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_addr_q  <= slot_addr_d;
         slot_write_q <= slot_write_d;
         slot_wdata_q <= slot_wdata_d;
         slot_strb_q  <= slot_strb_d;
         slot_id_q    <= slot_id_d;
      end
   end

   // Channel request drive: one-hot valid, shared payload straight from the slot.
   always_comb begin
      ch_req_valid_o = '0;
      if (slot_valid_q) begin
         ch_req_valid_o[slot_id_q] = 1'b1;
      end
      ch_req_addr_o  = slot_addr_q;
      ch_req_write_o = slot_write_q;
      ch_req_wdata_o = slot_wdata_q;
      ch_req_strb_o  = slot_strb_q;
   end

   // In-order response steering: only the channel at the FIFO head is listened to.
   always_comb begin
      rsp_valid_o    = 1'b0;
      ch_rsp_ready_o = '0;
      rsp_rdata_o    = ch_rsp_rdata_i[int'(head.id)*DataWidth +: DataWidth];
      rsp_write_o    = head.write;
      if (!order_empty) begin
         rsp_valid_o               = ch_rsp_valid_i[head.id];
         ch_rsp_ready_o[head.id]   = rsp_ready_i;
      end
      pop = rsp_valid_o && rsp_ready_i;
   end

   // Order FIFO holding {channel, write} for every accepted request.
   fifo_v3 #(
      .DataWidth ($bits(order_entry_t)),
      .Depth     (OrderDepth)
   ) i_order_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (order_full),
      .empty_o (order_empty),
      .usage_o (order_usage)
   );

   assign outstanding_o = order_usage;

endmodule

// File: tb/tb_l2_chan_router.sv
// Directed bench for l2_chan_router: mapping, ordering, full, backpressure and reset.
module tb_l2_chan_router;

   localparam int unsigned NumCh     = 4;
   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 512;
   localparam int unsigned StrbW     = DataWidth / 8;
   localparam int unsigned CntW      = 4;

   typedef logic [511:0] vec_t;

   logic                       clk_i = 1'b0;
   logic                       rst_i;
   logic                       req_valid_i;
   logic                       req_ready_o;
   logic [AddrWidth-1:0]       req_addr_i;
   logic                       req_write_i;
   logic [DataWidth-1:0]       req_wdata_i;
   logic [StrbW-1:0]           req_strb_i;
   logic [NumCh-1:0]           ch_req_valid_o;
   logic [NumCh-1:0]           ch_req_ready_i;
   logic [AddrWidth-1:0]       ch_req_addr_o;
   logic                       ch_req_write_o;
   logic [DataWidth-1:0]       ch_req_wdata_o;
   logic [StrbW-1:0]           ch_req_strb_o;
   logic [NumCh-1:0]           ch_rsp_valid_i;
   logic [NumCh-1:0]           ch_rsp_ready_o;
   logic [NumCh*DataWidth-1:0] ch_rsp_rdata_i;
   logic                       rsp_valid_o;
   logic                       rsp_ready_i;
   logic [DataWidth-1:0]       rsp_rdata_o;
   logic                       rsp_write_o;
   logic [CntW-1:0]            outstanding_o;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t d_w1, d_r1, d_c2, d_c0, d_c3;

   always #5 clk_i = ~clk_i;

   l2_chan_router dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_addr_i     (req_addr_i),
      .req_write_i    (req_write_i),
      .req_wdata_i    (req_wdata_i),
      .req_strb_i     (req_strb_i),
      .ch_req_valid_o (ch_req_valid_o),
      .ch_req_ready_i (ch_req_ready_i),
      .ch_req_addr_o  (ch_req_addr_o),
      .ch_req_write_o (ch_req_write_o),
      .ch_req_wdata_o (ch_req_wdata_o),
      .ch_req_strb_o  (ch_req_strb_o),
      .ch_rsp_valid_i (ch_rsp_valid_i),
      .ch_rsp_ready_o (ch_rsp_ready_o),
      .ch_rsp_rdata_i (ch_rsp_rdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_write_o    (rsp_write_o),
      .outstanding_o  (outstanding_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input vec_t obs, input vec_t exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic [31:0] addr, input logic wr, input vec_t data);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_write_i = wr;
      req_wdata_i = data;
      req_strb_i  = '1;
   endtask

   initial begin
      d_w1 = {16{32'hA5A5_0001}};
      d_r1 = {16{32'h1111_0001}};
      d_c2 = {16{32'h2222_0002}};
      d_c0 = {16{32'h0000_C0C0}};
      d_c3 = {16{32'h3333_0003}};

      rst_i          = 1'b1;
      req_valid_i    = 1'b0;
      req_addr_i     = '0;
      req_write_i    = 1'b0;
      req_wdata_i    = '0;
      req_strb_i     = '0;
      ch_req_ready_i = 4'b1111;
      ch_rsp_valid_i = '0;
      ch_rsp_rdata_i = '0;
      rsp_ready_i    = 1'b0;

      // reset values while reset is held
      tick();
      chk("rst_ch_req_valid", vec_t'(ch_req_valid_o), vec_t'(4'b0000));
      chk("rst_rsp_valid",    vec_t'(rsp_valid_o),    vec_t'(1'b0));
      chk("rst_ch_rsp_ready", vec_t'(ch_rsp_ready_o), vec_t'(4'b0000));
      chk("rst_outstanding",  vec_t'(outstanding_o),  vec_t'(4'd0));
      chk("rst_req_ready",    vec_t'(req_ready_o),    vec_t'(1'b1));
      rst_i = 1'b0;
      tick();

      // write 0x8000_2040 -> channel 1, address 0x8000_0040
      drive_req(32'h8000_2040, 1'b1, d_w1);
      #1;
      chk("map1_req_ready", vec_t'(req_ready_o), vec_t'(1'b1));
      tick();
      req_valid_i = 1'b0;
      chk("map1_valid",  vec_t'(ch_req_valid_o), vec_t'(4'b0010));
      chk("map1_addr",   vec_t'(ch_req_addr_o),  vec_t'(32'h8000_0040));
      chk("map1_write",  vec_t'(ch_req_write_o), vec_t'(1'b1));
      chk("map1_wdata",  vec_t'(ch_req_wdata_o), d_w1);
      chk("map1_strb",   vec_t'(ch_req_strb_o),  vec_t'({64{1'b1}}));
      chk("map1_outst",  vec_t'(outstanding_o),  vec_t'(4'd1));
      tick();
      chk("map1_drained", vec_t'(ch_req_valid_o), vec_t'(4'b0000));
      ch_rsp_valid_i = 4'b0010;
      ch_rsp_rdata_i[1*DataWidth +: DataWidth] = d_r1;
      rsp_ready_i = 1'b1;
      #1;
      chk("map1_rsp_valid", vec_t'(rsp_valid_o),    vec_t'(1'b1));
      chk("map1_rsp_write", vec_t'(rsp_write_o),    vec_t'(1'b1));
      chk("map1_rsp_data",  vec_t'(rsp_rdata_o),    d_r1);
      chk("map1_rsp_ready", vec_t'(ch_rsp_ready_o), vec_t'(4'b0010));
      tick();
      ch_rsp_valid_i = '0;
      rsp_ready_i    = 1'b0;
      chk("map1_popped", vec_t'(outstanding_o), vec_t'(4'd0));

      // stray channel response while empty is ignored
      ch_rsp_valid_i = 4'b0100;
      rsp_ready_i    = 1'b1;
      #1;
      chk("empty_rsp_valid", vec_t'(rsp_valid_o),    vec_t'(1'b0));
      chk("empty_rsp_ready", vec_t'(ch_rsp_ready_o), vec_t'(4'b0000));
      ch_rsp_valid_i = '0;
      rsp_ready_i    = 1'b0;

      // read 0x8000_6000 -> channel 3, address 0x8000_0000
      drive_req(32'h8000_6000, 1'b0, '0);
      tick();
      req_valid_i = 1'b0;
      chk("map2_valid", vec_t'(ch_req_valid_o), vec_t'(4'b1000));
      chk("map2_addr",  vec_t'(ch_req_addr_o),  vec_t'(32'h8000_0000));
      chk("map2_write", vec_t'(ch_req_write_o), vec_t'(1'b0));
      tick();
      ch_rsp_valid_i = 4'b1000;
      ch_rsp_rdata_i[3*DataWidth +: DataWidth] = d_c3;
      rsp_ready_i = 1'b1;
      #1;
      chk("map2_rsp_data",  vec_t'(rsp_rdata_o), d_c3);
      chk("map2_rsp_write", vec_t'(rsp_write_o), vec_t'(1'b0));
      tick();
      ch_rsp_valid_i = '0;
      rsp_ready_i    = 1'b0;
      chk("map2_popped", vec_t'(outstanding_o), vec_t'(4'd0));

      // ordering: read ch2 then ch0; ch0 answers first
      drive_req(32'h0000_4000, 1'b0, '0);
      tick();
      drive_req(32'h0000_0100, 1'b0, '0);
      tick();
      req_valid_i = 1'b0;
      chk("ord_outst", vec_t'(outstanding_o), vec_t'(4'd2));
      ch_rsp_rdata_i[2*DataWidth +: DataWidth] = d_c2;
      ch_rsp_rdata_i[0*DataWidth +: DataWidth] = d_c0;
      ch_rsp_valid_i = 4'b0001;
      rsp_ready_i    = 1'b1;
      #1;
      chk("ord_hold_valid", vec_t'(rsp_valid_o),    vec_t'(1'b0));
      chk("ord_hold_ready", vec_t'(ch_rsp_ready_o), vec_t'(4'b0100));
      tick();
      chk("ord_hold_outst", vec_t'(outstanding_o), vec_t'(4'd2));
      ch_rsp_valid_i = 4'b0101;
      #1;
      chk("ord_first_valid", vec_t'(rsp_valid_o), vec_t'(1'b1));
      chk("ord_first_data",  vec_t'(rsp_rdata_o), d_c2);
      tick();
      chk("ord_second_valid", vec_t'(rsp_valid_o),    vec_t'(1'b1));
      chk("ord_second_data",  vec_t'(rsp_rdata_o),    d_c0);
      chk("ord_second_ready", vec_t'(ch_rsp_ready_o), vec_t'(4'b0001));
      tick();
      ch_rsp_valid_i = '0;
      rsp_ready_i    = 1'b0;
      chk("ord_done_outst", vec_t'(outstanding_o), vec_t'(4'd0));

      // full: eight accepts with no responses
      for (int i = 0; i < 8; i++) begin
         drive_req(32'(i * 64), 1'b0, '0);
         tick();
      end
      drive_req(32'h0000_0400, 1'b0, '0);
      #1;
      chk("full_outst",     vec_t'(outstanding_o), vec_t'(4'd8));
      chk("full_req_ready", vec_t'(req_ready_o),   vec_t'(1'b0));
      tick();
      chk("full_no_push",   vec_t'(outstanding_o),  vec_t'(4'd8));
      chk("full_slot_empty", vec_t'(ch_req_valid_o), vec_t'(4'b0000));
      ch_rsp_valid_i = 4'b0001;
      rsp_ready_i    = 1'b1;
      #1;
      chk("full_pop_valid",  vec_t'(rsp_valid_o), vec_t'(1'b1));
      chk("full_no_bypass",  vec_t'(req_ready_o), vec_t'(1'b0));
      tick();
      req_valid_i    = 1'b0;
      ch_rsp_valid_i = '0;
      rsp_ready_i    = 1'b0;
      #1;
      chk("full_after_pop_ready", vec_t'(req_ready_o),   vec_t'(1'b1));
      chk("full_after_pop_outst", vec_t'(outstanding_o), vec_t'(4'd7));
      ch_rsp_valid_i = 4'b0001;
      rsp_ready_i    = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      ch_rsp_valid_i = '0;
      rsp_ready_i    = 1'b0;
      chk("full_drained", vec_t'(outstanding_o), vec_t'(4'd0));

      // backpressure on channel 1 for five cycles
      ch_req_ready_i = 4'b1101;
      drive_req(32'h0000_2000, 1'b0, '0);
      tick();
      drive_req(32'h0000_0010, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid",     vec_t'(ch_req_valid_o), vec_t'(4'b0010));
         chk("bp_addr",      vec_t'(ch_req_addr_o),  vec_t'(32'h0000_0000));
         chk("bp_req_ready", vec_t'(req_ready_o),    vec_t'(1'b0));
         chk("bp_outst",     vec_t'(outstanding_o),  vec_t'(4'd1));
         tick();
      end
      ch_req_ready_i = 4'b1111;
      #1;
      chk("bp_release_ready", vec_t'(req_ready_o), vec_t'(1'b1));
      tick();
      req_valid_i = 1'b0;
      chk("bp_second_valid", vec_t'(ch_req_valid_o), vec_t'(4'b0001));
      chk("bp_second_addr",  vec_t'(ch_req_addr_o),  vec_t'(32'h0000_0010));
      chk("bp_second_outst", vec_t'(outstanding_o),  vec_t'(4'd2));
      tick();
      ch_rsp_valid_i = 4'b0011;
      rsp_ready_i    = 1'b1;
      #1;
      chk("bp_rsp_valid", vec_t'(rsp_valid_o), vec_t'(1'b1));
      tick();
      tick();
      ch_rsp_valid_i = '0;
      rsp_ready_i    = 1'b0;
      chk("bp_drained", vec_t'(outstanding_o), vec_t'(4'd0));

      // mid-operation reset with three outstanding and the slot full
      ch_req_ready_i = 4'b1111;
      drive_req(32'h0000_0000, 1'b0, '0);
      tick();
      drive_req(32'h0000_0040, 1'b0, '0);
      tick();
      drive_req(32'h0000_0080, 1'b0, '0);
      tick();
      req_valid_i    = 1'b0;
      ch_req_ready_i = 4'b0000;
      chk("mrst_pre_outst", vec_t'(outstanding_o),  vec_t'(4'd3));
      chk("mrst_pre_slot",  vec_t'(ch_req_valid_o), vec_t'(4'b0001));
      rst_i          = 1'b1;
      ch_rsp_valid_i = 4'b0001;
      rsp_ready_i    = 1'b1;
      tick();
      chk("mrst_ch_req_valid", vec_t'(ch_req_valid_o), vec_t'(4'b0000));
      chk("mrst_rsp_valid",    vec_t'(rsp_valid_o),    vec_t'(1'b0));
      chk("mrst_ch_rsp_ready", vec_t'(ch_rsp_ready_o), vec_t'(4'b0000));
      chk("mrst_outstanding",  vec_t'(outstanding_o),  vec_t'(4'd0));
      chk("mrst_req_ready",    vec_t'(req_ready_o),    vec_t'(1'b1));
      rst_i = 1'b0;
      tick();
      chk("mrst_late_rsp_valid", vec_t'(rsp_valid_o),    vec_t'(1'b0));
      chk("mrst_late_rsp_ready", vec_t'(ch_rsp_ready_o), vec_t'(4'b0000));
      chk("mrst_late_outst",     vec_t'(outstanding_o),  vec_t'(4'd0));
      ch_rsp_valid_i = '0;
      rsp_ready_i    = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
